// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial_to_parallel deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package s2p_pkg;

  // PARITY is reachable only when SERIAL_TO_PARALLEL_PARITY_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } s2p_state_t;

  // XOR over data bits and parity bit must equal this value.
  localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/s2p_out_reg.sv
// Single-entry valid/ready holding register for completed words.
// Latency: load_vld on edge N -> out_vld high from edge N (1 cycle after the last serial bit).
// Backpressure: a load while full and out_rdy=0 drops the new word and pulses overflow next cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   load_vld, load_dat    completed word offered this cycle
//   out_vld, out_rdy      registered valid/ready output handshake
//   out_dat               held word (not cleared on accept)
//   overflow              1-cycle pulse: offered word dropped because register stayed full
module s2p_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_vld,
  input  logic [WIDTH-1:0] load_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             overflow
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    ovf_d = 1'b0;
    if (vld_q && out_rdy) begin
      vld_d = 1'b0;
    end
    // A simultaneous accept frees the slot, so the new word can replace the old one on the same edge.
    if (load_vld) begin
      if (!vld_q || out_rdy) begin
        vld_d = 1'b1;
        dat_d = load_dat;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_dat  = dat_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/serial_to_parallel.sv
// Deserializer: LSB-first serial bit stream to parallel words with framing/parity error flags.
// Latency: word valid 1 cycle after its last serial bit (parity bit when SERIAL_TO_PARALLEL_PARITY_EN).
// Backpressure: single holding register; a word completing while it is full and not accepted is dropped (overflow).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   serial_valid, serial_data     input bit stream, held valid for one full frame per word
//   parallel_valid/ready/data     registered valid/ready word output
//   overflow, frame_error         1-cycle error pulses
//   parity_error                  1-cycle pulse; tied 0 unless SERIAL_TO_PARALLEL_PARITY_EN is defined
// Optional macro: SERIAL_TO_PARALLEL_PARITY_EN adds a trailing even-parity bit per frame.
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_valid,
  input  logic             serial_data,
  output logic             parallel_valid,
  input  logic             parallel_ready,
  output logic [width-1:0] parallel_data,
  output logic             overflow,
  output logic             frame_error,
  output logic             parity_error
);

  localparam int CNT_W = $clog2(width) + 1;
  localparam int IDX_W = $clog2(width);

  s2p_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [width-1:0] shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             load_vld;
  logic [width-1:0] load_dat;
  logic             last_bit;

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  assign last_bit = (cnt_q == CNT_W'(width - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    load_vld    = 1'b0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    parity_err_d = 1'b0;
    load_dat     = shift_q;
`else
    // Bypass the last bit straight into the holding register so it loads on the same edge.
    load_dat            = shift_q;
    load_dat[width-1]   = serial_data;
`endif

    case (state_q)
      IDLE: begin
        if (serial_valid) begin
          shift_d[0] = serial_data;
          cnt_d      = CNT_W'(1);
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (serial_valid) begin
          shift_d[cnt_q[IDX_W-1:0]] = serial_data;
          if (last_bit) begin
            cnt_d = '0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
            state_d = PARITY;
`else
            state_d  = IDLE;
            load_vld = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
      PARITY: begin
        state_d = IDLE;
        if (serial_valid) begin
          if ((^shift_q ^ serial_data) == PARITY_EVEN) begin
            load_vld = 1'b1;
          end else begin
            parity_err_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
`endif

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_error = parity_err_q;
`else
  assign parity_error = 1'b0;
`endif

  assign frame_error = frame_err_q;

  s2p_out_reg #(
    .WIDTH (width)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load_vld (load_vld),
    .load_dat (load_dat),
    .out_vld  (parallel_valid),
    .out_rdy  (parallel_ready),
    .out_dat  (parallel_data),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_serial_to_parallel.sv
module tb_serial_to_parallel;

  localparam int W = 8;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  localparam int FR = W + 1;
  localparam bit PAR_MODE = 1'b1;
`else
  localparam int FR = W;
  localparam bit PAR_MODE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         serial_valid = 1'b0;
  logic         serial_data = 1'b0;
  logic         parallel_valid;
  logic         parallel_ready = 1'b0;
  logic [W-1:0] parallel_data;
  logic         overflow;
  logic         frame_error;
  logic         parity_error;

  serial_to_parallel #(.width(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_valid   (serial_valid),
    .serial_data    (serial_data),
    .parallel_valid (parallel_valid),
    .parallel_ready (parallel_ready),
    .parallel_data  (parallel_data),
    .overflow       (overflow),
    .frame_error    (frame_error),
    .parity_error   (parity_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects a frame's bits in a queue, packs them arithmetically,
  // and decides the fate of each completed word against a one-slot occupancy flag.
  logic [W-1:0] exp_q[$];
  bit           frame_bits[$];
  bit           held = 1'b0;
  bit           exp_ovf = 1'b0, exp_fe = 1'b0, exp_pe = 1'b0;
  logic [W-1:0] word;
  bit           par_ok;

  always @(posedge clk) begin
    if (rst) begin
      held = 1'b0;
      frame_bits.delete();
      exp_q.delete();
      exp_ovf = 1'b0; exp_fe = 1'b0; exp_pe = 1'b0;
    end else begin
      exp_ovf = 1'b0; exp_fe = 1'b0; exp_pe = 1'b0;
      if (held && parallel_ready) held = 1'b0;
      if (serial_valid) begin
        frame_bits.push_back(serial_data);
        if (frame_bits.size() == FR) begin
          word = '0;
          for (int i = 0; i < W; i++) word = word + (W'(frame_bits[i]) << i);
          par_ok = 1'b1;
          if (PAR_MODE) begin
            int ones = 0;
            for (int i = 0; i < FR; i++) ones += int'(frame_bits[i]);
            par_ok = (ones % 2) == 0;
          end
          if (!par_ok) exp_pe = 1'b1;
          else if (held) exp_ovf = 1'b1;
          else begin
            held = 1'b1;
            exp_q.push_back(word);
          end
          frame_bits.delete();
        end
      end else if (frame_bits.size() > 0) begin
        exp_fe = 1'b1;
        frame_bits.delete();
      end
    end
  end

  // Monitor: compares flags every cycle and pops the scoreboard on each DUT handshake.
  logic [W-1:0] got_word;
  always @(negedge clk) begin
    if (!rst) begin
      chk("parallel_valid", 32'(parallel_valid), 32'(held));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("frame_error", 32'(frame_error), 32'(exp_fe));
      chk("parity_error", 32'(parity_error), 32'(exp_pe));
      if (parallel_valid && parallel_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(parallel_data), 32'hFFFF_FFFF);
        end else begin
          got_word = exp_q.pop_front();
          chk("parallel_data", 32'(parallel_data), 32'(got_word));
        end
      end
    end
  end

  task automatic drive(input logic sv, input logic sd, input logic rdy);
    serial_valid   = sv;
    serial_data    = sd;
    parallel_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), rdy);
  endtask

  task automatic send(input logic [W-1:0] w, input logic rdy, input logic last_rdy,
                      input bit rand_rdy, input bit bad_par);
    logic [W-1:0] lw;
    logic         b;
    logic         r;
    lw = w;
    for (int i = 0; i < FR; i++) begin
      if (i < W) b = lw[i];
      else       b = (^lw) ^ bad_par;
      if (rand_rdy)        r = 1'($urandom_range(0, 1));
      else if (i == FR-1)  r = last_rdy;
      else                 r = rdy;
      drive(1'b1, b, r);
    end
  endtask

  initial begin
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_valid", 32'(parallel_valid), 32'd0);
    chk("rst_data", 32'(parallel_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_error", 32'(frame_error), 32'd0);
    chk("rst_parity_error", 32'(parity_error), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2, 1'b1);

    // Single word, always ready.
    send(8'h4D, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Back-to-back words.
    send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Second word completes while the first is stalled: overflow, first word kept.
    send(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // Completion coincides with accept: replace without overflow.
    send(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Truncated frame then a full word.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    send(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Reset mid-word: no error pulse, next word clean.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    send(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    if (PAR_MODE) begin
      send(8'h4D, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(3, 1'b1);
    end

    // Randomized traffic: random data, gaps, back-pressure, truncations, bad parity.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        int n;
        n = $urandom_range(1, FR - 1);
        for (int i = 0; i < n; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end else begin
        send(W'($urandom), 1'b0, 1'b0, 1'b1, PAR_MODE && ($urandom_range(0, 7) == 0));
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end

    idle(5, 1'b1);
    @(negedge clk);
    chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(parallel_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
